word_memory_array: RTL and testbench

- Parametrised successor to the single-bit cell: a DEPTH x WIDTH word-addressed storage array with chip select, separate write and read strobes, and a registered read port.
- Adds a hardware clear sequencer that zeroes every word after reset or on request.
- Sits below the register-file and scratchpad logic as the generic storage primitive.

---
 rtl/word_memory_array.sv | 138 +++++++++++++
 tb/tb_word_memory_array.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/word_memory_array.sv
// word_memory_array: DEPTH x WIDTH word-addressed storage with chip select,
// separate write and read strobes, a registered read port (one cycle of
// latency) and a hardware clear sequencer that zeroes every word after reset
// or on an init pulse.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous active-high reset (restarts the clear sweep)
//   cs       chip select; w and r are ignored when low
//   w, r     write / read strobes
//   addr     word address (unsigned; addr >= DEPTH is out of range)
//   d_in     write data
//   init     single-cycle pulse that starts a clear sweep from IDLE
//   d_out    read data
//   rd_valid one-cycle pulse: d_out carries fresh read data
//   busy     clear sweep in progress; requests are dropped
//
// Optional build macro: TRISTATE_OUT_EN
//   defined   -> d_out is all-z whenever rd_valid is low (shared data bus)
//   undefined -> d_out is a plain register holding the last read value
//
// state    | meaning
// ST_IDLE  | accepting read/write requests, busy=0
// ST_CLEAR | zeroing word[ptr] each cycle, busy=1

module word_memory_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              w,
  input  logic              r,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              init,
  output logic [WIDTH-1:0]  d_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int                IDX_W    = $clog2(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  d_out_q, d_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [WIDTH-1:0]  mem_wdata;
  logic              addr_ok;
  logic              req_ok;
  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  ptr_idx;

  always_comb begin
    addr_ok    = ({1'b0, addr} < DEPTH_X);
    addr_idx   = addr[IDX_W-1:0];
    ptr_idx    = ptr_q[IDX_W-1:0];
    req_ok     = cs && (state_q == ST_IDLE);
    state_d    = state_q;
    ptr_d      = ptr_q;
    d_out_d    = d_out_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = addr_idx;
    mem_wdata  = d_in;

    case (state_q)
      ST_IDLE: begin
        // Read samples the array before this edge's write commits, so a
        // same-cycle read/write to one address returns the old word.
        if (req_ok && r) begin
          rd_valid_d = 1'b1;
          d_out_d    = addr_ok ? mem_q[addr_idx] : '0;
        end
        if (req_ok && w && addr_ok) begin
          mem_we = 1'b1;
        end
        if (init) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = ptr_idx;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      d_out_q    <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      d_out_q    <= d_out_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      if (mem_we) begin
        mem_q[mem_idx] <= mem_wdata;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

`ifdef TRISTATE_OUT_EN
  assign d_out = rd_valid_q ? d_out_q : {WIDTH{1'bz}};
`else
  assign d_out = d_out_q;
`endif

endmodule

// File: tb/tb_word_memory_array.sv
// Bench for word_memory_array: two instances (DEPTH=16 and DEPTH=12, both
// ADDR_W=4) share one stimulus stream; each is compared every cycle against
// a behavioural model of the array, plus directed spot checks.

module tb_word_memory_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cs, w, r, init;
  logic [3:0] addr;
  logic [7:0] d_in;
  logic [7:0] d_out_a, d_out_b;
  logic       rdv_a, rdv_b, busy_a, busy_b;

  word_memory_array #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut_a (
    .clk(clk), .rst(rst), .cs(cs), .w(w), .r(r), .addr(addr), .d_in(d_in),
    .init(init), .d_out(d_out_a), .rd_valid(rdv_a), .busy(busy_a)
  );

  word_memory_array #(.WIDTH(8), .DEPTH(12), .ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst), .cs(cs), .w(w), .r(r), .addr(addr), .d_in(d_in),
    .init(init), .d_out(d_out_b), .rd_valid(rdv_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference: word contents, remaining clear cycles, last read result.
  logic [7:0] ref_mem   [2][16];
  int         ref_sweep [2];
  logic [7:0] ref_dout  [2];
  logic       ref_vld   [2];
  int         ref_depth [2] = '{16, 12};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_update(input int k);
    int a;
    a = int'(addr);
    if (rst) begin
      ref_sweep[k] = ref_depth[k];
      ref_dout[k]  = 8'h00;
      ref_vld[k]   = 1'b0;
    end else if (ref_sweep[k] > 0) begin
      ref_mem[k][ref_depth[k] - ref_sweep[k]] = 8'h00;
      ref_sweep[k]--;
      ref_vld[k] = 1'b0;
    end else begin
      ref_vld[k] = cs && r;
      if (cs && r) ref_dout[k] = (a < ref_depth[k]) ? ref_mem[k][a] : 8'h00;
      if (cs && w && a < ref_depth[k]) ref_mem[k][a] = d_in;
      if (init) ref_sweep[k] = ref_depth[k];
    end
  endtask

  function automatic logic [7:0] exp_dout(input int k);
`ifdef TRISTATE_OUT_EN
    return ref_vld[k] ? ref_dout[k] : 8'hzz;
`else
    return ref_dout[k];
`endif
  endfunction

  task automatic step(input logic i_rst, input logic i_cs, input logic i_w,
                      input logic i_r, input logic [3:0] i_addr,
                      input logic [7:0] i_d, input logic i_init);
    rst = i_rst; cs = i_cs; w = i_w; r = i_r;
    addr = i_addr; d_in = i_d; init = i_init;
    @(posedge clk);
    ref_update(0);
    ref_update(1);
    #1;
    check_eq("a_busy",  32'(busy_a),  32'(ref_sweep[0] > 0));
    check_eq("a_vld",   32'(rdv_a),   32'(ref_vld[0]));
    check_eq("a_dout",  32'(d_out_a), 32'(exp_dout(0)));
    check_eq("b_busy",  32'(busy_b),  32'(ref_sweep[1] > 0));
    check_eq("b_vld",   32'(rdv_b),   32'(ref_vld[1]));
    check_eq("b_dout",  32'(d_out_b), 32'(exp_dout(1)));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00, 1'b0);
  endtask

  // Counts busy samples of dut_a starting with the current one; pulses rst
  // or init after the given number of busy samples (0 = never).
  task automatic measure_busy(input int rst_at, input int init_at,
                              output int cnt);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy_a) break;
      cnt++;
      step(cnt == rst_at, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, cnt == init_at);
    end
  endtask

  initial begin
    int cnt;
    for (int k = 0; k < 2; k++) begin
      ref_sweep[k] = 0; ref_dout[k] = 8'h00; ref_vld[k] = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[k][i] = 8'h00;
    end
    rst = 1'b0; cs = 1'b0; w = 1'b0; r = 1'b0;
    addr = 4'h0; d_in = 8'h00; init = 1'b0;
    @(posedge clk); #1;

    // Reset sweep: busy for exactly 16 cycles, then everything reads 0.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    check_eq("rst_dout", 32'(d_out_a), 32'(exp_dout(0)));
    measure_busy(0, 0, cnt);
    check_eq("rst_busy_len", 32'(cnt), 32'd16);
    for (int i = 0; i < 16; i++) rd(4'(i));

    // Write/read, back-to-back reads.
    wr(4'd3, 8'hA5);
    wr(4'd15, 8'h5A);
    rd(4'd3);
    check_eq("wr_rd3", 32'(d_out_a), 32'hA5);
    rd(4'd15);
    check_eq("wr_rd15", 32'(d_out_a), 32'h5A);
    check_eq("wr_rd15_vld", 32'(rdv_a), 32'd1);
    idle();
    check_eq("vld_pulse", 32'(rdv_a), 32'd0);

    // Read during write returns old data.
    wr(4'd7, 8'h11);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 8'h22, 1'b0);
    check_eq("rdw_old", 32'(d_out_a), 32'h11);
    rd(4'd7);
    check_eq("rdw_new", 32'(d_out_a), 32'h22);

    // cs gating.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 8'hFF, 1'b0);
    rd(4'd2);
    check_eq("cs_gate", 32'(d_out_a), 32'h00);

    // Out-of-range on the DEPTH=12 instance.
    wr(4'd13, 8'h3C);
    rd(4'd13);
    check_eq("oor_dout", 32'(d_out_b), 32'h00);
    check_eq("oor_vld", 32'(rdv_b), 32'd1);

    // init clears, requests during busy dropped.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 8'h77, 1'b0);
    check_eq("busy_drop_vld", 32'(rdv_a), 32'd0);
    measure_busy(0, 0, cnt);
    for (int i = 0; i < 16; i++) rd(4'(i));

    // rst at sweep cycle 9 restarts a full 16-cycle sweep.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    measure_busy(9, 0, cnt);
    check_eq("mid_rst_len", 32'(cnt), 32'd25);

    // init at sweep cycle 5 does not extend the sweep.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    measure_busy(0, 5, cnt);
    check_eq("mid_init_len", 32'(cnt), 32'd16);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)),
           8'($urandom),
           $urandom_range(0, 79) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
